// File: rtl/tour_cmd.sv
// tour_cmd: replays a solved knight's tour as cmd_proc move commands.
// Each one-hot move code is issued as a vertical leg (opcode 4), then a
// horizontal leg (opcode 5). While idle, UART commands pass straight through.
module tour_cmd #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic             clr_cmd_rdy_UART,
    output logic [7:0]       resp,
    output logic             tour_err
);

    localparam logic [7:0]       HEAD_N    = 8'h00;
    localparam logic [7:0]       HEAD_W    = 8'h3F;
    localparam logic [7:0]       HEAD_S    = 8'h7F;
    localparam logic [7:0]       HEAD_E    = 8'hBF;
    localparam logic [7:0]       RESP_DONE = 8'hA5;
    localparam logic [7:0]       RESP_LEG  = 8'h5A;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOVES - 1);

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    state_t      state, nxt_state;
    logic        move_legal;
    logic [1:0]  dx_mag, dy_mag;
    logic        dx_neg, dy_neg;
    logic [15:0] vert_cmd, horz_cmd;
    logic        init_indx, inc_indx, set_resp_leg, set_resp_done;

    // Decode the one-hot move code into signed x/y offsets (sign + magnitude)
    always_comb begin
        move_legal = 1'b1;
        dx_mag     = 2'd0;
        dx_neg     = 1'b0;
        dy_mag     = 2'd0;
        dy_neg     = 1'b0;
        case (move)
            8'h01: begin dx_mag = 2'd1;                  dy_mag = 2'd2;                  end
            8'h02: begin dx_mag = 2'd1; dx_neg = 1'b1;   dy_mag = 2'd2;                  end
            8'h04: begin dx_mag = 2'd2; dx_neg = 1'b1;   dy_mag = 2'd1;                  end
            8'h08: begin dx_mag = 2'd2; dx_neg = 1'b1;   dy_mag = 2'd1; dy_neg = 1'b1;   end
            8'h10: begin dx_mag = 2'd1; dx_neg = 1'b1;   dy_mag = 2'd2; dy_neg = 1'b1;   end
            8'h20: begin dx_mag = 2'd1;                  dy_mag = 2'd2; dy_neg = 1'b1;   end
            8'h40: begin dx_mag = 2'd2;                  dy_mag = 2'd1; dy_neg = 1'b1;   end
            8'h80: begin dx_mag = 2'd2;                  dy_mag = 2'd1;                  end
            default: move_legal = 1'b0;
        endcase
    end

    assign vert_cmd = {4'h4, (dy_neg ? HEAD_S : HEAD_N), 2'b00, dy_mag};
    assign horz_cmd = {4'h5, (dx_neg ? HEAD_W : HEAD_E), 2'b00, dx_mag};

    // Next-state and output logic; the UART path is only connected while idle
    always_comb begin
        nxt_state        = state;
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        tour_err         = 1'b0;
        init_indx        = 1'b0;
        inc_indx         = 1'b0;
        set_resp_leg     = 1'b0;
        set_resp_done    = 1'b0;
        case (state)
            IDLE: begin
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                if (start_tour) begin
                    init_indx = 1'b1;
                    nxt_state = VERT;
                end
            end
            VERT: begin
                cmd = vert_cmd;
                if (!move_legal) begin
                    tour_err      = 1'b1;
                    set_resp_done = 1'b1;
                    nxt_state     = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy) nxt_state = WAIT_V;
                end
            end
            WAIT_V: begin
                cmd = vert_cmd;
                if (send_resp) begin
                    set_resp_leg = 1'b1;
                    nxt_state    = HORZ;
                end
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) nxt_state = WAIT_H;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (send_resp) begin
                    if (mv_indx == LAST_IDX) begin
                        set_resp_done = 1'b1;
                        nxt_state     = IDLE;
                    end else begin
                        inc_indx     = 1'b1;
                        set_resp_leg = 1'b1;
                        nxt_state    = VERT;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // Move index: cleared at tour start, advanced after each horizontal leg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mv_indx <= '0;
        else if (init_indx) mv_indx <= '0;
        else if (inc_indx)  mv_indx <= mv_indx + 1'b1;
    end

    // Response byte: 0x5A per completed leg, 0xA5 at tour end or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             resp <= RESP_DONE;
        else if (set_resp_done) resp <= RESP_DONE;
        else if (set_resp_leg)  resp <= RESP_LEG;
    end

endmodule

// File: tb/tb_tour_cmd.sv
// tb_tour_cmd: randomized self-checking bench for tour_cmd; the bench plays
// tour_logic (move ROM) and cmd_proc (handshake) around the DUT.
module tb_tour_cmd;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;
    localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy_UART;
    logic [7:0]       resp;
    logic             tour_err;

    logic [7:0] rom [32];
    int total = 0;
    int bad = 0;
    int issued = 0;

    assign move = rom[mv_indx];

    tour_cmd #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .resp(resp),
        .tour_err(tour_err)
    );

    always #5 clk = ~clk;

    // Reference model: leg commands from the move's dx/dy offsets
    function automatic int bit_of(input logic [7:0] code);
        int b = 0;
        for (int k = 0; k < 8; k++) if (code[k]) b = k;
        return b;
    endfunction

    function automatic logic [15:0] exp_vert(input logic [7:0] code);
        int dy = DY[bit_of(code)];
        return {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    endfunction

    function automatic logic [15:0] exp_horz(input logic [7:0] code);
        int dx = DX[bit_of(code)];
        return {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    endfunction

    task automatic fill_rom_random();
        for (int i = 0; i < 32; i++) rom[i] = 8'(1 << $urandom_range(7, 0));
    endtask

    task automatic do_reset();
        start_tour = 0; clr_cmd_rdy = 0; send_resp = 0; cmd_rdy_UART = 0; cmd_UART = 16'h0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic start_pulse();
        start_tour = 1;
        @(negedge clk);
        start_tour = 0;
    endtask

    // One leg as cmd_proc sees it; entered and left on a negedge
    task automatic host_leg(input logic [15:0] exp_cmd, input int exp_idx, input bit last,
                            input int clr_dly, input int resp_dly, input bit poke);
        int w = 0;
        while (cmd_rdy !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (cmd_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL leg_timeout: cmd_rdy=%b required 1 (idx %0d)", cmd_rdy, exp_idx);
            return;
        end
        issued++;
        total++;
        if (w != 0) begin
            bad++;
            $display("[TB] FAIL leg_latency: waited %0d cycles required 0 (idx %0d)", w, exp_idx);
        end
        total++;
        if (cmd !== exp_cmd) begin
            bad++;
            $display("[TB] FAIL leg_cmd: cmd=%h required %h (idx %0d)", cmd, exp_cmd, exp_idx);
        end
        total++;
        if (mv_indx !== IDX_W'(exp_idx)) begin
            bad++;
            $display("[TB] FAIL leg_indx: mv_indx=%0d required %0d", mv_indx, exp_idx);
        end
        for (int j = 0; j < clr_dly; j++) begin
            if (poke) begin
                send_resp  = (j == 3);
                start_tour = (j == 5);
            end
            @(negedge clk);
            total++;
            if (cmd !== exp_cmd || cmd_rdy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL leg_hold: cmd=%h rdy=%b required %h/1", cmd, cmd_rdy, exp_cmd);
            end
        end
        send_resp = poke;
        start_tour = 0;
        clr_cmd_rdy = 1;
        #1;
        total++;
        if (clr_cmd_rdy_UART !== 1'b0) begin
            bad++;
            $display("[TB] FAIL leg_clr_uart: clr_cmd_rdy_UART=%b required 0", clr_cmd_rdy_UART);
        end
        @(negedge clk);
        clr_cmd_rdy = 0;
        send_resp = 0;
        total++;
        if (cmd_rdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL leg_rdy_drop: cmd_rdy=%b required 0", cmd_rdy);
        end
        repeat (resp_dly) @(negedge clk);
        send_resp = 1;
        @(negedge clk);
        send_resp = 0;
        total++;
        if (resp !== (last ? 8'hA5 : 8'h5A)) begin
            bad++;
            $display("[TB] FAIL leg_resp: resp=%h required %h", resp, last ? 8'hA5 : 8'h5A);
        end
    endtask

    task automatic test_reset();
        start_tour = 0; clr_cmd_rdy = 0; send_resp = 0; cmd_rdy_UART = 0; cmd_UART = 16'hC3C3;
        fill_rom_random();
        rst_n = 0;
        @(negedge clk);
        total++;
        if (mv_indx !== '0 || cmd_rdy !== 1'b0 || tour_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctl: indx=%0d rdy=%b err=%b required 0/0/0", mv_indx, cmd_rdy, tour_err);
        end
        total++;
        if (resp !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL reset_resp: resp=%h required a5", resp);
        end
        total++;
        if (cmd !== 16'hC3C3) begin
            bad++;
            $display("[TB] FAIL reset_cmd: cmd=%h required c3c3", cmd);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_idle_passthrough();
        for (int i = 0; i < 8; i++) begin
            cmd_UART     = (i == 0) ? 16'h4BF2 : 16'($urandom);
            cmd_rdy_UART = (i == 0) ? 1'b1 : 1'($urandom);
            clr_cmd_rdy  = 1'($urandom);
            #1;
            total++;
            if (cmd !== cmd_UART || cmd_rdy !== cmd_rdy_UART || clr_cmd_rdy_UART !== clr_cmd_rdy) begin
                bad++;
                $display("[TB] FAIL idle_pass: cmd=%h rdy=%b clr=%b required %h/%b/%b",
                         cmd, cmd_rdy, clr_cmd_rdy_UART, cmd_UART, cmd_rdy_UART, clr_cmd_rdy);
            end
            total++;
            if (resp !== 8'hA5) begin
                bad++;
                $display("[TB] FAIL idle_resp: resp=%h required a5", resp);
            end
            @(negedge clk);
        end
        cmd_rdy_UART = 0;
        clr_cmd_rdy = 0;
        @(negedge clk);
    endtask

    task automatic test_single_move();
        fill_rom_random();
        rom[0] = 8'h80;
        start_pulse();
        host_leg(16'h4001, 0, 1'b0, 2, 1, 1'b0);
        host_leg(16'h5BF2, 0, 1'b0, 0, 0, 1'b0);
        total++;
        if (mv_indx !== 5'd1 || cmd_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_next: indx=%0d rdy=%b required 1/1", mv_indx, cmd_rdy);
        end
        do_reset();
    endtask

    task automatic test_full_tour();
        fill_rom_random();
        for (int i = 0; i < 8; i++) rom[i] = 8'(1 << i);
        issued = 0;
        start_pulse();
        for (int i = 0; i < NUM_MOVES; i++) begin
            host_leg(exp_vert(rom[i]), i, 1'b0, $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
            host_leg(exp_horz(rom[i]), i, i == NUM_MOVES - 1, $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
        end
        repeat (4) begin
            @(negedge clk);
            total++;
            if (cmd_rdy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL tour_extra: cmd_rdy=%b required 0", cmd_rdy);
            end
        end
        total++;
        if (issued != 2 * NUM_MOVES) begin
            bad++;
            $display("[TB] FAIL tour_count: issued=%0d required %0d", issued, 2 * NUM_MOVES);
        end
        cmd_UART = 16'($urandom);
        cmd_rdy_UART = 1;
        #1;
        total++;
        if (cmd !== cmd_UART || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL tour_end_idle: cmd=%h rdy=%b resp=%h required %h/1/a5", cmd, cmd_rdy, resp, cmd_UART);
        end
        @(negedge clk);
        cmd_rdy_UART = 0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [7:0] bad_codes [4] = '{8'h03, 8'h00, 8'hFF, 8'h81};
        for (int t = 0; t < 4; t++) begin
            int at = (t == 0) ? 5 : 0;
            fill_rom_random();
            rom[at] = bad_codes[t];
            start_pulse();
            for (int i = 0; i < at; i++) begin
                host_leg(exp_vert(rom[i]), i, 1'b0, $urandom_range(2, 0), $urandom_range(2, 0), 1'b0);
                host_leg(exp_horz(rom[i]), i, 1'b0, $urandom_range(2, 0), $urandom_range(2, 0), 1'b0);
            end
            total++;
            if (tour_err !== 1'b1 || cmd_rdy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL err_pulse: err=%b rdy=%b required 1/0 (code %h)", tour_err, cmd_rdy, bad_codes[t]);
            end
            @(negedge clk);
            total++;
            if (tour_err !== 1'b0 || resp !== 8'hA5) begin
                bad++;
                $display("[TB] FAIL err_after: err=%b resp=%h required 0/a5", tour_err, resp);
            end
            cmd_UART = 16'($urandom);
            cmd_rdy_UART = 1;
            #1;
            total++;
            if (cmd !== cmd_UART || cmd_rdy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL err_idle: cmd=%h rdy=%b required %h/1", cmd, cmd_rdy, cmd_UART);
            end
            @(negedge clk);
            cmd_rdy_UART = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_handshake();
        fill_rom_random();
        start_pulse();
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1;
        host_leg(exp_vert(rom[0]), 0, 1'b0, 0, 0, 1'b0);
        host_leg(exp_horz(rom[0]), 0, 1'b0, 1, 1, 1'b0);
        host_leg(exp_vert(rom[1]), 1, 1'b0, 50, 2, 1'b1);
        host_leg(exp_horz(rom[1]), 1, 1'b0, 2, 0, 1'b1);
        host_leg(exp_vert(rom[2]), 2, 1'b0, 0, 0, 1'b0);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        total++;
        if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL uart_pending: cmd=%h rdy=%b required 1234/1", cmd, cmd_rdy);
        end
        @(negedge clk);
        cmd_rdy_UART = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_tour();
        fill_rom_random();
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            host_leg(exp_vert(rom[i]), i, 1'b0, $urandom_range(2, 0), $urandom_range(2, 0), 1'b0);
            host_leg(exp_horz(rom[i]), i, 1'b0, $urandom_range(2, 0), $urandom_range(2, 0), 1'b0);
        end
        host_leg(exp_vert(rom[10]), 10, 1'b0, 1, 0, 1'b0);
        clr_cmd_rdy = 1;
        @(negedge clk);
        clr_cmd_rdy = 0;
        repeat (2) @(negedge clk);
        total++;
        if (mv_indx !== 5'd10 || cmd_rdy !== 1'b0 || resp !== 8'h5A) begin
            bad++;
            $display("[TB] FAIL mid_pre: indx=%0d rdy=%b resp=%h required 10/0/5a", mv_indx, cmd_rdy, resp);
        end
        rst_n = 0;
        #1;
        total++;
        if (mv_indx !== '0 || cmd_rdy !== 1'b0 || resp !== 8'hA5 || tour_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset: indx=%0d rdy=%b resp=%h err=%b required 0/0/a5/0",
                     mv_indx, cmd_rdy, resp, tour_err);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start_pulse();
        host_leg(exp_vert(rom[0]), 0, 1'b0, 0, 1, 1'b0);
        host_leg(exp_horz(rom[0]), 0, 1'b0, 1, 0, 1'b0);
        total++;
        if (mv_indx !== 5'd1) begin
            bad++;
            $display("[TB] FAIL mid_restart: indx=%0d required 1", mv_indx);
        end
        do_reset();
    endtask

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        test_reset();
        test_idle_passthrough();
        test_single_move();
        test_full_tour();
        test_illegal();
        test_handshake();
        test_reset_mid_tour();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Sits between tour_logic and cmd_proc inside KnightsTour.
- Replays a solved knight's tour: reads one-hot move codes by index, then issues each as two cmd_proc move commands, a vertical leg followed by a horizontal leg.
- Multiplexes these commands with UART-sourced commands, and generates the response byte sent back to the host.

Parameters:
- NUM_MOVES, 24: number of moves in a tour (indices 0..NUM_MOVES-1).
- IDX_W, 5: width of mv_indx.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_tour  in  1  one-cycle pulse from cmd_proc when tour_logic has finished solving
- move  in  8  one-hot move code at mv_indx, from tour_logic
- mv_indx  out  IDX_W  move index presented to tour_logic
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy  in  1  cmd_proc consumed the current cmd
- send_resp  in  1  one-cycle pulse when cmd_proc completes a command
- cmd  out  16  command to cmd_proc
- cmd_rdy  out  1  cmd valid to cmd_proc
- clr_cmd_rdy_UART  out  1  consume strobe to UART wrapper
- resp  out  8  response byte
- tour_err  out  1  one-cycle pulse on an illegal move code

Behaviour:

Command format:
- cmd[15:12] is the opcode: 4 = move, 5 = move with fanfare.
- cmd[11:4] is the heading: N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
- cmd[3:0] is the number of squares.

Move decode (bit -> dx,dy):
- bit0 +1,+2; bit1 -1,+2; bit2 -2,+1; bit3 -2,-1
- bit4 -1,-2; bit5 +1,-2; bit6 +2,-1; bit7 +2,+1
- Vertical leg: opcode 4, heading N if dy>0 else S, squares = |dy|.
- Horizontal leg: opcode 5, heading E if dx>0 else W, squares = |dx|.
- Example: bit7 -> 16'h4001 then 16'h5BF2.
- A code that is not one-hot (zero or multiple bits set) is illegal.

State machine, states IDLE, VERT, WAIT_V, HORZ, WAIT_H:
- IDLE:
  - Combinational pass-through: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy.
  - On start_tour: mv_indx <= 0, go to VERT.
  - start_tour outside IDLE is ignored.
- VERT:
  - If move is illegal: pulse tour_err, go to IDLE.
  - Otherwise drive cmd = vertical leg with cmd_rdy = 1, holding both stable until clr_cmd_rdy, then go to WAIT_V.
  - cmd_rdy deasserts the cycle after clr_cmd_rdy.
- WAIT_V: cmd_rdy = 0; on send_resp go to HORZ.
- HORZ: drive the horizontal leg with cmd_rdy = 1 until clr_cmd_rdy, then go to WAIT_H.
- WAIT_H: on send_resp:
  - If mv_indx == NUM_MOVES-1, go to IDLE.
  - Otherwise increment mv_indx and go to VERT.
- Outside IDLE:
  - clr_cmd_rdy_UART = 0.
  - UART commands are ignored; cmd_rdy_UART stays pending and is serviced after returning to IDLE.
- move is sampled combinationally in VERT and HORZ. tour_logic holds it stable for a stable mv_indx.

resp:
- 8'hA5 in IDLE.
- 8'hA5 on the send_resp that completes the final horizontal leg.
- 8'h5A for every other send_resp during a tour, so the host sees 0x5A per leg and 0xA5 at tour end.
- Registered: updated on the state transition.

Simultaneous events:
- clr_cmd_rdy and send_resp in the same cycle while in VERT or HORZ: clr_cmd_rdy advances the state; send_resp is ignored.
- send_resp while in VERT or HORZ is ignored.

Reset values:
- Asynchronous reset, including mid-tour, returns the block to IDLE.
- mv_indx = 0, cmd_rdy = 0, tour_err = 0, resp = 8'hA5.
- cmd in IDLE follows cmd_UART.

Latency:
- cmd_rdy for the first leg is asserted 1 cycle after start_tour.
- Each subsequent leg asserts cmd_rdy 1 cycle after the send_resp that ends the previous leg.

Test Plan:
- Idle pass-through: cmd_UART = 16'h4BF2, cmd_rdy_UART = 1 -> cmd = 16'h4BF2 and cmd_rdy = 1 the same cycle; clr_cmd_rdy reaches clr_cmd_rdy_UART; resp = 8'hA5.
- Single legal move, move = 8'h80 at index 0: start_tour -> cmd 16'h4001 with cmd_rdy = 1.
  - clr_cmd_rdy, then send_resp -> resp = 8'h5A, cmd 16'h5BF2.
  - clr_cmd_rdy, then send_resp -> mv_indx = 1.
- Full tour with NUM_MOVES = 24 driven from a ROM of the 8 codes: exactly 48 commands issued.
  - Each command has the correct heading and squares, e.g. bit3 -> 16'h47F1 then 16'h53F2.
  - Final send_resp -> resp = 8'hA5, state IDLE, UART path restored.
- Illegal code move = 8'h03 at index 5 -> tour_err pulses one cycle, no cmd_rdy, return to IDLE, resp = 8'hA5.
- Handshake robustness: clr_cmd_rdy delayed by 50 cycles -> cmd held stable throughout.
  - send_resp asserted in VERT -> ignored, no state change.
  - UART cmd_rdy_UART asserted mid-tour -> not forwarded, and clr_cmd_rdy_UART = 0.
- Reset mid-tour, asserted in WAIT_H at mv_indx = 10 -> mv_indx = 0, cmd_rdy = 0, resp = 8'hA5.
  - A new start_tour afterwards restarts at index 0.
